// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM states and frame geometry.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned WORD_W         = 32;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses a length/words/checksum byte frame, writes words to memory,
// and holds the CPU in reset until the image is written and verified.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] MAX_N     = 16'(MAX_WORDS);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t            state, state_nx;
  logic [15:0]       len;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [WORD_W-9:0] shift_q;
  logic [7:0]        csum;
  logic              take, arm, word_end, last_word;
  logic [15:0]       req_len;

  assign take      = in_valid && in_ready;
  assign arm       = start && (state == IDLE || state == DONE || state == ERROR);
  assign word_end  = (byte_cnt == LAST_BYTE);
  assign last_word = (16'(word_cnt) == len - 16'd1);
  assign req_len   = {len[15:8], in_data};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nx = LEN_HI;
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (req_len > MAX_N)      state_nx = ERROR;
          else if (req_len == '0)   state_nx = CHECK;
          else                      state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && word_end && last_word) state_nx = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == csum) ? DONE : ERROR;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign done     = (state == DONE);
  assign err      = (state == ERROR);
  assign cpu_hold = (state != DONE);

  // Only the low three bytes are kept; the fourth arrives on in_data and completes the word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len       <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shift_q   <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (arm) begin
        len      <= '0;
        word_cnt <= '0;
        byte_cnt <= '0;
        shift_q  <= '0;
        csum     <= '0;
      end
      if (take) begin
        case (state)
          LEN_HI: len[15:8] <= in_data;
          LEN_LO: len[7:0]  <= in_data;
          DATA: begin
            shift_q  <= {shift_q[WORD_W-17:0], in_data};
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (word_end) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[ADDR_W-1:0];
              mem_wdata <= {shift_q, in_data};
              word_cnt  <= word_cnt + (ADDR_W+1)'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a frame-level reference of expected writes and outcome.
module tb_prog_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 1024;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [ADDR_W+31:0] act_q[$];

  always @(negedge CLK) if (mem_we) act_q.push_back({mem_addr, mem_wdata});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"},   64'(mem_we),   64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_err"},      64'(err),      64'd0);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Offer one byte, with in_valid randomly withheld; garbage data while not valid.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
    bit ok, now;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge CLK);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? b : 8'($urandom);
      now = in_valid && in_ready;
      @(posedge CLK);
      if (now) ok = 1'b1;
    end
    #1 in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] n, input logic [31:0] words[$],
                           input bit bad_csum, input int unsigned gap_pct, input bit busy_start);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [31:0] w;
    logic [ADDR_W+31:0] exp_q[$];
    bit oversize;
    oversize = (n > 16'(MAX_WORDS));
    x = 8'h00;
    for (int i = 0; i < int'(n) && !oversize; i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        bytes.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
      exp_q.push_back({ADDR_W'(i), w});
    end
    if (bad_csum) x ^= 8'h01;

    pulse_start();
    chk({tag, "_arm_hold"},  64'(cpu_hold), 64'd1);
    chk({tag, "_arm_done"},  64'(done),     64'd0);
    chk({tag, "_arm_err"},   64'(err),      64'd0);
    act_q.delete();
    send_byte(n[15:8], gap_pct);
    send_byte(n[7:0], gap_pct);
    if (oversize) begin
      chk({tag, "_ovr_err"}, 64'(err), 64'd1);
      for (int t = 0; t < 4; t++) begin
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        chk({tag, "_ovr_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
    end else begin
      foreach (bytes[i]) begin
        if (busy_start && i == 2) pulse_start();
        send_byte(bytes[i], gap_pct);
      end
      chk({tag, "_pre_hold"}, 64'(cpu_hold), 64'd1);
      send_byte(x, gap_pct);
    end
    chk({tag, "_done"},  64'(done),     64'(!oversize && !bad_csum));
    chk({tag, "_err"},   64'(err),      64'(oversize || bad_csum));
    chk({tag, "_hold"},  64'(cpu_hold), 64'(oversize || bad_csum));
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < act_q.size()) chk({tag, "_wr"}, 64'(act_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] wq[$];
    logic [31:0] none[$];
    logic [31:0] rq[$];
    logic [15:0] n;

    #1 check_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 check_reset_outputs("idle");

    wq = '{32'h28220005, 32'hFC000000};
    run_frame("nominal", 16'd2, wq, 1'b0, 0, 1'b0);
    run_frame("badsum", 16'd2, wq, 1'b1, 0, 1'b0);
    run_frame("empty", 16'd0, none, 1'b0, 0, 1'b0);
    run_frame("empty_bad", 16'd0, none, 1'b1, 0, 1'b0);
    run_frame("oversize", 16'd1025, none, 1'b0, 0, 1'b0);
    run_frame("gaps", 16'd2, wq, 1'b0, 60, 1'b1);

    // abandon a load after the 6th byte
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h28, 0);
    send_byte(8'h22, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    run_frame("after_rst", 16'd2, wq, 1'b0, 20, 1'b0);

    for (int r = 0; r < 10; r++) begin
      n = 16'($urandom_range(0, 6));
      rq.delete();
      for (int i = 0; i < int'(n); i++) rq.push_back($urandom);
      run_frame("rand", n, rq, ($urandom_range(3) == 0), $urandom_range(0, 70),
                ($urandom_range(1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
